// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: sequences lookup and write commands from an upstream port
// onto an external CAM with a one-cycle registered lookup result, returns
// lookup results downstream and keeps saturating hit/miss statistics.
//
// Optional feature macro: CAM_LEARN_EN
//   When defined, every miss is followed by a LEARN cycle that writes the
//   missed key into the slot pointed to by a round-robin learn_ptr.
//
// Handshake rule for both the in_* and res_* ports: a beat transfers on a
// rising clk edge where valid and ready are both 1. The producer holds
// valid and keeps its payload stable until that edge. Ready never depends
// combinationally on valid.
module cam_lookup_ctrl #(
  parameter int NB_MEM = 14,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // upstream command port
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wr,
  input  logic [7:0]       in_key,
  input  logic [4:0]       in_addr,
  // CAM side
  output logic             cam_enable,
  output logic             cam_write,
  output logic [4:0]       cam_addr,
  output logic [7:0]       cam_data,
  input  logic [4:0]       cam_out,
  input  logic             cam_found,
  // downstream result port
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [4:0]       res_index,
  // statistics
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             wr_err,
  // debug view of the controller state
  output logic [2:0]       dbg_state
);

`ifdef CAM_LEARN_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3,
    WRITE   = 3'd4,
    LEARN   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3,
    WRITE   = 3'd4
  } state_t;
`endif

  localparam logic [4:0]       NB_MEM_A = 5'(NB_MEM);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] key_q;
  logic [4:0] addr_q;
  logic       accept;
  logic       wr_ok;

`ifdef CAM_LEARN_EN
  localparam logic [4:0] LAST_A = 5'(NB_MEM - 1);
  logic [4:0] learn_ptr;
`endif

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign accept    = in_ready && in_valid;
  // Writes outside the CAM are refused at the door; the command kind is
  // captured by which state the FSM enters, so in_wr needs no own register.
  assign wr_ok     = (in_addr < NB_MEM_A);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and CAM drive; the CAM bus is idle-zero outside
  // LOOKUP, WRITE and LEARN.
  always_comb begin
    state_d    = state_q;
    cam_enable = 1'b0;
    cam_write  = 1'b0;
    cam_addr   = '0;
    cam_data   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!in_wr)     state_d = LOOKUP;
          else if (wr_ok) state_d = WRITE;
        end
      end
      LOOKUP: begin
        cam_enable = 1'b1;
        cam_data   = key_q;
        state_d    = CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        if (res_ready) begin
`ifdef CAM_LEARN_EN
          state_d = res_hit ? IDLE : LEARN;
`else
          state_d = IDLE;
`endif
        end
      end
      WRITE: begin
        cam_write = 1'b1;
        cam_addr  = addr_q;
        cam_data  = key_q;
        state_d   = IDLE;
      end
`ifdef CAM_LEARN_EN
      LEARN: begin
        cam_write = 1'b1;
        cam_addr  = learn_ptr;
        cam_data  = key_q;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Command capture on acceptance and sticky write-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      addr_q <= '0;
      wr_err <= 1'b0;
    end else if (accept) begin
      key_q  <= in_key;
      addr_q <= in_addr;
      if (in_wr && !wr_ok) wr_err <= 1'b1;
    end
  end

  // Result capture and saturating statistics, both taken in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hit   <= 1'b0;
      res_index <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else if (state_q == CAPTURE) begin
      res_hit <= cam_found;
      if (cam_found) begin
        res_index <= cam_out;
        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
`ifdef CAM_LEARN_EN
        // A miss reports the slot the following LEARN cycle will fill.
        res_index <= learn_ptr;
`else
        res_index <= '0;
`endif
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

`ifdef CAM_LEARN_EN
  // Round-robin learn pointer, advanced only by LEARN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      learn_ptr <= '0;
    end else if (state_q == LEARN) begin
      learn_ptr <= (learn_ptr == LAST_A) ? '0 : learn_ptr + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// tb_cam_lookup_ctrl: drives cam_lookup_ctrl against a behavioural CAM and
// compares results, CAM writes and statistics with a reference model.
// Build with +define+CAM_LEARN_EN to exercise miss-learning.
module tb_cam_lookup_ctrl;
  localparam int NB_MEM = 14;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_wr = 1'b0;
  logic [7:0]       in_key = '0;
  logic [4:0]       in_addr = '0;
  logic             cam_enable;
  logic             cam_write;
  logic [4:0]       cam_addr;
  logic [7:0]       cam_data;
  logic [4:0]       cam_out = '0;
  logic             cam_found = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             res_hit;
  logic [4:0]       res_index;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             wr_err;
  logic [2:0]       dbg_state;

  cam_lookup_ctrl #(.NB_MEM(NB_MEM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
    .in_key(in_key), .in_addr(in_addr),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_index(res_index), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .wr_err(wr_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  int         hs_cnt  = 0;
  logic [12:0] exp_q[$];   // expected CAM writes {addr, data}
  logic [12:0] wr_log[$];  // observed CAM writes {addr, data}

  // reference model
  logic [7:0] m_key[NB_MEM];
  logic       m_vld[NB_MEM] = '{default: 1'b0};
  int         m_hit = 0;
  int         m_miss = 0;
  logic       m_wr_err = 1'b0;
  int         m_ptr = 0;

  // behavioural CAM (environment), one-cycle registered lookup
  logic [7:0] cam_mem_key[NB_MEM];
  logic       cam_mem_vld[NB_MEM] = '{default: 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (cam_write) begin
      wr_log.push_back({cam_addr, cam_data});
      if (cam_addr < 5'(NB_MEM)) begin
        cam_mem_key[cam_addr] <= cam_data;
        cam_mem_vld[cam_addr] <= 1'b1;
      end
    end
    if (cam_enable) begin
      cam_found <= 1'b0;
      cam_out   <= '0;
      for (int i = NB_MEM - 1; i >= 0; i--)
        if (cam_mem_vld[i] && cam_mem_key[i] == cam_data) begin
          cam_found <= 1'b1;
          cam_out   <= 5'(i);
        end
    end
  end

  always @(posedge clk) if (rst_n && res_valid && res_ready) hs_cnt <= hs_cnt + 1;

  always @(negedge clk) begin
    check("cam_excl", {31'd0, cam_enable & cam_write}, 0);
    if (!cam_enable && !cam_write) begin
      check("cam_addr_idle", {27'd0, cam_addr}, 0);
      check("cam_data_idle", {24'd0, cam_data}, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  task automatic model_lookup(input logic [7:0] key, output logic hit, output logic [4:0] idx);
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NB_MEM; i++)
      if (!hit && m_vld[i] && m_key[i] == key) begin
        hit = 1'b1;
        idx = 5'(i);
      end
`ifdef CAM_LEARN_EN
    if (!hit) idx = 5'(m_ptr);
`endif
  endtask

  task automatic check_writes();
    logic [12:0] g;
    logic [12:0] e;
    check("wr_count", wr_log.size(), exp_q.size());
    while (wr_log.size() > 0 && exp_q.size() > 0) begin
      g = wr_log.pop_front();
      e = exp_q.pop_front();
      check("wr_beat", {19'd0, g}, {19'd0, e});
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 0);
    check({tag, "_res_hit"}, {31'd0, res_hit}, 0);
    check({tag, "_res_index"}, {27'd0, res_index}, 0);
    check({tag, "_cam_en"}, {31'd0, cam_enable}, 0);
    check({tag, "_cam_wr"}, {31'd0, cam_write}, 0);
    check({tag, "_cam_addr"}, {27'd0, cam_addr}, 0);
    check({tag, "_cam_data"}, {24'd0, cam_data}, 0);
    check({tag, "_hit_cnt"}, {30'd0, hit_cnt}, 0);
    check({tag, "_miss_cnt"}, {30'd0, miss_cnt}, 0);
    check({tag, "_wr_err"}, {31'd0, wr_err}, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("idle_timeout", {31'd0, in_ready}, 1);
  endtask

  task automatic reset_release();
    in_valid  = 1'b0;
    res_ready = 1'b1;
    m_hit = 0; m_miss = 0; m_wr_err = 1'b0; m_ptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_release();
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [7:0] key);
    wait_idle();
    in_valid = 1'b1; in_wr = 1'b1; in_addr = addr; in_key = key;
    @(posedge clk); #1;
    in_valid = 1'b0; in_wr = 1'b0;
    if (addr < NB_MEM) begin
      m_key[addr] = key;
      m_vld[addr] = 1'b1;
      exp_q.push_back({addr, key});
      check("wr_busy", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      check("wr_done", {31'd0, in_ready}, 1);
    end else begin
      m_wr_err = 1'b1;
      check("wr_drop_rdy", {31'd0, in_ready}, 1);
    end
    check("wr_err", {31'd0, wr_err}, {31'd0, m_wr_err});
    check_writes();
  endtask

  // hold = number of RESP cycles with res_ready low (0 = ready throughout)
  task automatic do_lookup(input logic [7:0] key, input int hold);
    logic       e_hit;
    logic [4:0] e_idx;
    int         n;
    int         hs0;
    model_lookup(key, e_hit, e_idx);
    wait_idle();
    res_ready = (hold == 0);
    in_valid = 1'b1; in_wr = 1'b0; in_key = key; in_addr = 5'($urandom_range(0, 31));
    @(posedge clk); #1;
    in_valid = 1'b0;
    hs0 = hs_cnt;
    check("lk_cam_en", {31'd0, cam_enable}, 1);
    check("lk_cam_data", {24'd0, cam_data}, {24'd0, key});
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("lk_valid", {31'd0, res_valid}, 1);
    if (!res_valid) return;
    // visible after 2 edges, so the handshake lands on the 3rd edge
    check("lk_lat", n, 2);
    if (e_hit) m_hit  = (m_hit  == CMAX) ? CMAX : m_hit + 1;
    else       m_miss = (m_miss == CMAX) ? CMAX : m_miss + 1;
    check("lk_hit", {31'd0, res_hit}, {31'd0, e_hit});
    check("lk_idx", {27'd0, res_index}, {27'd0, e_idx});
    check("hit_cnt", {30'd0, hit_cnt}, m_hit);
    check("miss_cnt", {30'd0, miss_cnt}, m_miss);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, res_valid}, 1);
      check("hold_idx", {27'd0, res_index}, {27'd0, e_idx});
      check("hold_rdy", {31'd0, in_ready}, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_once", hs_cnt - hs0, 1);
    check("post_valid", {31'd0, res_valid}, 0);
`ifdef CAM_LEARN_EN
    if (!e_hit) begin
      exp_q.push_back({5'(m_ptr), key});
      m_key[m_ptr] = key;
      m_vld[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % NB_MEM;
    end
`endif
    wait_idle();
    check_writes();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hs0;
    #2 rst_n = 1'b0;
    #1 check_reset_outs("por");
    reset_release();
    wr_log.delete();

`ifdef CAM_LEARN_EN
    // 15 distinct absent keys: learn slots 0..13 then wrap to 0
    for (int i = 0; i < 15; i++) do_lookup(8'hA0 + 8'(i), 0);
    check("learn_wrap_idx", {27'd0, res_index}, 0);
    do_reset();
`endif

    do_write(5'd3, 8'h5A);
    do_lookup(8'h5A, 0);
    check("dir_hit_idx", {27'd0, res_index}, 3);
    check("dir_hit_cnt", {30'd0, hit_cnt}, 1);
    do_lookup(8'h77, 0);
    check("dir_miss_cnt", {30'd0, miss_cnt}, 1);
    do_lookup(8'h5A, 5);
    do_write(5'd14, 8'h33);
    check("dir_wr_err", {31'd0, wr_err}, 1);

    // reset asserted while in CAPTURE
    wait_idle();
    in_valid = 1'b1; in_wr = 1'b0; in_key = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    hs0 = hs_cnt;
    rst_n = 1'b0;
    #1 check_reset_outs("rst_cap");
    reset_release();
    repeat (4) begin
      check("rst_no_resp", {31'd0, res_valid}, 0);
      @(posedge clk); #1;
    end
    check("rst_no_hs", hs_cnt - hs0, 0);
    check_writes();

    // saturation: 5 hits on a 2-bit counter
    do_write(5'd7, 8'h42);
    repeat (5) do_lookup(8'h42, 0);
    check("sat_hit_cnt", {30'd0, hit_cnt}, 3);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_write(5'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
      else
        do_lookup(8'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
    check("final_wr_err", {31'd0, wr_err}, {31'd0, m_wr_err});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
